// File: rtl/midi_gate.sv
// midi_gate: MIDI note-on/off parser with a last-note-priority key stack that drives one adsr voice.
// Define MIDI_GATE_LEGATO_EN to hold gate high across overlapping note-ons instead of retriggering.
module midi_gate #(
  parameter int CHANNEL     = 0,
  parameter int STACK_DEPTH = 4,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          gate,
  output logic [6:0]    note,
  output logic [6:0]    velocity,
  output logic [DW-1:0] depth
);

`ifdef MIDI_GATE_LEGATO_EN
  localparam bit LEGATO = 1'b1;
`else
  localparam bit LEGATO = 1'b0;
`endif

  localparam logic [3:0] CH = 4'(CHANNEL);

  typedef enum logic [1:0] {ST_IDLE, ST_KEY, ST_VAL, ST_IGNORE} state_t;
  typedef enum logic [1:0] {MSG_OFF, MSG_ON, MSG_CC} msg_t;

  state_t state, state_nx;
  msg_t   msg;
  logic [6:0] key_q;

  logic is_sys, is_status, is_data, tracked;
  logic exec_on, exec_off, exec_clr;

  logic [6:0]    stk_key [STACK_DEPTH];
  logic [6:0]    stk_vel [STACK_DEPTH];
  logic [DW-1:0] cnt;

  logic [6:0] rem_key  [STACK_DEPTH];
  logic [6:0] rem_vel  [STACK_DEPTH];
  logic [6:0] push_key [STACK_DEPTH];
  logic [6:0] push_vel [STACK_DEPTH];
  logic [6:0] nx_key   [STACK_DEPTH];
  logic [6:0] nx_vel   [STACK_DEPTH];
  logic [6:0] nx_note, nx_velocity;
  logic       nx_gate, found;
  int         cnt_i, rem_cnt, push_cnt, nx_cnt;

  // Byte classification; real-time bytes (0xF8-0xFF) fall into no class and are invisible.
  always_comb begin
    is_sys    = in_valid && (in_data[7:3] == 5'b11110);
    is_status = in_valid && in_data[7] && (in_data[7:4] != 4'hF);
    is_data   = in_valid && !in_data[7];
    tracked   = (in_data[3:0] == CH) &&
                (in_data[7:4] == 4'h8 || in_data[7:4] == 4'h9 || in_data[7:4] == 4'hB);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (is_sys) begin
      state_nx = ST_IDLE;
    end else if (is_status) begin
      state_nx = tracked ? ST_KEY : ST_IGNORE;
    end else if (is_data) begin
      case (state)
        ST_KEY:  state_nx = ST_VAL;
        ST_VAL:  state_nx = ST_KEY;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    exec_on  = 1'b0;
    exec_off = 1'b0;
    exec_clr = 1'b0;
    if (is_data && state == ST_VAL) begin
      case (msg)
        MSG_ON: begin
          if (in_data[6:0] != 7'd0) exec_on = 1'b1;
          else                      exec_off = 1'b1;
        end
        MSG_OFF: exec_off = 1'b1;
        default: exec_clr = (key_q == 7'd123);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msg   <= MSG_OFF;
      key_q <= 7'd0;
    end else begin
      if (is_status && tracked) begin
        case (in_data[7:4])
          4'h9:    msg <= MSG_ON;
          4'hB:    msg <= MSG_CC;
          default: msg <= MSG_OFF;
        endcase
      end
      if (is_data && state == ST_KEY) key_q <= in_data[6:0];
    end
  end

  assign cnt_i = int'(cnt);

  // Remove key_q if held: entries at and above the match slide down one slot.
  always_comb begin
    found = 1'b0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      rem_key[i] = stk_key[i];
      rem_vel[i] = stk_vel[i];
    end
    for (int i = 0; i < STACK_DEPTH - 1; i++) begin
      if (i < cnt_i && stk_key[i] == key_q) found = 1'b1;
      if (found) begin
        rem_key[i] = stk_key[i+1];
        rem_vel[i] = stk_vel[i+1];
      end
    end
    if (cnt_i == STACK_DEPTH && stk_key[STACK_DEPTH-1] == key_q) found = 1'b1;
    rem_cnt = found ? cnt_i - 1 : cnt_i;
  end

  // Push onto the removal result, dropping the oldest entry when full.
  always_comb begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      push_key[i] = rem_key[i];
      push_vel[i] = rem_vel[i];
    end
    if (rem_cnt == STACK_DEPTH) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) begin
        push_key[i] = rem_key[i+1];
        push_vel[i] = rem_vel[i+1];
      end
      push_key[STACK_DEPTH-1] = key_q;
      push_vel[STACK_DEPTH-1] = in_data[6:0];
      push_cnt = STACK_DEPTH;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (i == rem_cnt) begin
          push_key[i] = key_q;
          push_vel[i] = in_data[6:0];
        end
      end
      push_cnt = rem_cnt + 1;
    end
  end

  // Select the next stack; note/velocity follow the top and hold when the stack empties.
  always_comb begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      nx_key[i] = stk_key[i];
      nx_vel[i] = stk_vel[i];
    end
    nx_cnt = cnt_i;
    if (exec_clr) begin
      nx_cnt = 0;
    end else if (exec_on) begin
      nx_key = push_key;
      nx_vel = push_vel;
      nx_cnt = push_cnt;
    end else if (exec_off) begin
      nx_key = rem_key;
      nx_vel = rem_vel;
      nx_cnt = rem_cnt;
    end
    nx_note     = note;
    nx_velocity = velocity;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (i == nx_cnt - 1) begin
        nx_note     = nx_key[i];
        nx_velocity = nx_vel[i];
      end
    end
    nx_gate = (nx_cnt != 0) && !(exec_on && !LEGATO && cnt_i != 0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stk_key[i] <= 7'd0;
        stk_vel[i] <= 7'd0;
      end
      cnt      <= '0;
      gate     <= 1'b0;
      note     <= 7'd0;
      velocity <= 7'd0;
    end else begin
      stk_key  <= nx_key;
      stk_vel  <= nx_vel;
      cnt      <= DW'(nx_cnt);
      gate     <= nx_gate;
      note     <= nx_note;
      velocity <= nx_velocity;
    end
  end

  assign depth = cnt;

endmodule

// File: doc/midi_gate.md
# midi_gate

Converts a byte-serial MIDI stream into the `gate`, note and velocity signals that drive one `adsr` voice. It decodes note-on/note-off with running status, keeps a small last-note-priority stack of held keys, and produces the `gate` consumed by the envelope generator. The block sits between the MIDI UART receiver and the `adsr`/oscillator pair.

## Interface
Parameters:
- `CHANNEL`, 0: MIDI channel (0–15) this voice answers to.
- `STACK_DEPTH`, 4: number of held keys remembered (2–16).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  one-cycle strobe; `in_data` is a received byte.
- `in_data`  in  8  MIDI byte.
- `gate`  out  1  high while at least one key is held; connects to `adsr.gate`.
- `note`  out  7  key number of the sounding (top-of-stack) note.
- `velocity`  out  7  velocity of the sounding note.
- `depth`  out  $clog2(STACK_DEPTH+1)  number of held keys.

## Operation
- Input is always accepted, at most one byte per cycle; there is no back-pressure.
- Byte classes:
  - 0xF8–0xFF (real-time): ignored; parser state and running status are unchanged.
  - 0xF0–0xF7: clears running status and enters IDLE.
  - 0x80–0xEF: sets running status. Only 0x8n, 0x9n and 0xBn with n==`CHANNEL` are tracked; any other status enters IGNORE.
- Parser states:
  - IDLE: data bytes are dropped.
  - KEY: the next data byte is latched as the key; go to VAL.
  - VAL: the next data byte is the velocity/value; the message executes and the parser returns to KEY (running status).
  - IGNORE: data bytes are dropped until the next status byte.
  - A status byte received in any state restarts at KEY (tracked status) or IGNORE (untracked), discarding any partial message.
- Messages:
  - Note-on, velocity > 0: remove the key from the stack if present, then push {key, velocity} on top. If the stack is full, the bottom (oldest) entry is discarded first.
  - Note-on with velocity 0, or note-off (release velocity ignored): remove the key if present and compact the entries above it downward. An absent key is a no-op.
  - CC 123 (all notes off), any value: empty the stack.
  - Other CC numbers: ignored.
- Outputs:
  - `gate` = stack non-empty, except during the retrigger cycle (see Configuration).
  - `note`/`velocity` = top entry.
  - When the stack empties, `note`/`velocity` hold their last values so that the `adsr` release sounds at the correct pitch.
  - Removing the top key while others remain switches to the new top without dropping `gate`.

## Timing
- Reset values:
  - `gate`=0, `note`=0, `velocity`=0, `depth`=0.
  - Stack empty, running status cleared, parser in IDLE.
- Reset mid-message discards the partial message.
- Latency: `gate`, `note`, `velocity` and `depth` change on the clock edge one cycle after the `in_valid` cycle carrying the completing data byte. All outputs are registered.
- Stack update (search, remove, compact, push) completes in that single cycle.
- Completing message in a cycle where `reset` is high: reset wins.
- Consecutive completing messages on back-to-back bytes are impossible, because each message needs at least 2 data bytes. Every message is therefore fully applied before the next one.

## Configuration
- `MIDI_GATE_LEGATO_EN` defined:
  - A note-on arriving while `gate`=1 updates `note`/`velocity` with `gate` held high, so the envelope continues.
- `MIDI_GATE_LEGATO_EN` undefined:
  - A note-on arriving while `gate`=1 drives `gate`=0 for exactly one cycle, with `note`/`velocity` already showing the new note.
  - `gate` returns to 1 on the following cycle, so `adsr` restarts its attack.
  - A note-off or stack pop never retriggers.
  - If the stack empties during the low cycle, `gate` stays 0.

## Test plan
- Reset, then with `CHANNEL`=0 send 0x90 0x3C 0x64 → one cycle after the last byte: `gate`=1, `note`=0x3C, `velocity`=0x64, `depth`=1. Then send 0x3C 0x00 (running status) → `gate`=0, `note` stays 0x3C, `depth`=0.
- Send 0x90 0x3C 0x40, then 0x40 0x50 → `note`=0x40, `depth`=2.
  - Legato off: `gate` is low for exactly 1 cycle.
  - Legato on: `gate` never drops.
  - Then send 0x80 0x40 0x00 → `note`=0x3C, `velocity`=0x40, `gate` stays 1.
- Press keys 1..5 with `STACK_DEPTH`=4 → `depth`=4. Release keys 5, 4, 3, 2 → key 1 has been dropped, so `gate`=0 after releasing key 2.
- Send 0x91 0x3C 0x64 (channel 1) → no output change. Insert 0xF8 between 0x90 and 0x3C of a valid message → the message executes normally.
- Hold 3 keys, send 0xB0 0x7B 0x00 → `depth`=0, `gate`=0.
- Assert `reset` between the key and velocity bytes → all outputs at reset values. A following lone data byte is ignored (parser in IDLE).
